// File: rtl/seq_divider16.sv
// ----------------------------------------------------------------------------
// seq_divider16
//   Multi-cycle restoring divider sitting beside the ALU. A start pulse
//   captures the dividend, divisor and signedness; one quotient bit is
//   produced per clock, then quotient/remainder are presented with a
//   one-cycle done strobe. Division by zero completes in one cycle with
//   quotient = all ones, remainder = dividend and div_zero set.
//
// Ports
//   Clk        in   1      system clock, rising edge
//   Reset_n    in   1      asynchronous active-low reset
//   start      in   1      division request, accepted while busy==0
//   is_signed  in   1      1 = two's-complement operands (sampled with start)
//   A          in   WIDTH  dividend (sampled with start)
//   B          in   WIDTH  divisor  (sampled with start)
//   quotient   out  WIDTH  quotient, valid from done, held afterwards
//   remainder  out  WIDTH  remainder, valid from done, held afterwards
//   busy       out  1      high while iterating
//   done       out  1      one-cycle pulse, results valid
//   div_zero   out  1      set with done when B==0, held with results
// ----------------------------------------------------------------------------
module seq_divider16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] rem_q;      // partial remainder
    logic [WIDTH-1:0] dvd_q;      // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dsr_q;      // divisor magnitude
    logic             neg_q_q;
    logic             neg_r_q;

    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             busy_q;
    logic             done_q;
    logic             div_zero_q;

    // Operand magnitudes; 0x8000 negates to itself and is then treated
    // as an unsigned magnitude, which the WIDTH+1-bit window handles.
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // One restoring step
    logic [WIDTH:0]   window;
    logic             fits;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] dvd_d;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    always_comb begin
        a_mag = (is_signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
        b_mag = (is_signed && B[WIDTH-1]) ? (~B + 1'b1) : B;
    end

    always_comb begin
        window = {rem_q, dvd_q[WIDTH-1]};
        fits   = (window >= {1'b0, dsr_q});
        // When the window fits, window - dsr < dsr, so the difference
        // always fits in WIDTH bits and the top bit can be dropped.
        rem_d  = fits ? (window[WIDTH-1:0] - dsr_q) : window[WIDTH-1:0];
        dvd_d  = {dvd_q[WIDTH-2:0], fits};
        q_final = neg_q_q ? (~dvd_d + 1'b1) : dvd_d;
        r_final = neg_r_q ? (~rem_d + 1'b1) : rem_d;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    if (start) begin
                        if (B == '0) begin
                            state_q     <= S_DONE;
                            quotient_q  <= '1;
                            remainder_q <= A;
                            div_zero_q  <= 1'b1;
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                            count_q <= CW'(WIDTH - 1);
                            rem_q   <= '0;
                            dvd_q   <= a_mag;
                            dsr_q   <= b_mag;
                            neg_q_q <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                            neg_r_q <= is_signed & A[WIDTH-1];
                        end
                    end
                end

                S_RUN: begin
                    rem_q <= rem_d;
                    dvd_q <= dvd_d;
                    if (count_q == '0) begin
                        // Final step result goes straight to the outputs
                        // so they change exactly on entry to DONE.
                        state_q     <= S_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        quotient_q  <= q_final;
                        remainder_q <= r_final;
                        div_zero_q  <= 1'b0;
                    end else begin
                        count_q <= count_q - 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_divider16.sv
// ----------------------------------------------------------------------------
// tb_seq_divider16
//   Self-checking bench for seq_divider16. Expected results come from plain
//   integer division (truncating, remainder takes dividend sign) on the
//   sampled operands, plus the fixed latency rules.
// ----------------------------------------------------------------------------
module tb_seq_divider16;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        done;
    logic        div_zero;

    int total = 0;
    int bad   = 0;

    seq_divider16 #(.WIDTH(16)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .start     (start),
        .is_signed (is_signed),
        .A         (A),
        .B         (B),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    always #5 Clk = ~Clk;

    // Reference: integer arithmetic on the operands.
    function automatic void ref_div(input logic [15:0] a, input logic [15:0] b,
                                    input logic s, output logic [15:0] q,
                                    output logic [15:0] r, output logic z,
                                    output int lat);
        int sa, sb;
        if (b == 16'd0) begin
            q = 16'hFFFF; r = a; z = 1'b1; lat = 1;
        end else begin
            if (s) begin
                sa = int'($signed(a));
                sb = int'($signed(b));
            end else begin
                sa = int'({16'd0, a});
                sb = int'({16'd0, b});
            end
            q = 16'(sa / sb);
            r = 16'(sa % sb);
            z = 1'b0;
            lat = 17;
        end
    endfunction

    // Issue one request and wait (bounded) for done. Leaves the bench #1
    // after the edge that opens the done cycle. lat = -1 on timeout.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          output int lat, output int busy_cycles);
        @(posedge Clk); #1;
        start = 1'b1; A = a; B = b; is_signed = s;
        @(posedge Clk); #1;
        start = 1'b0;
        lat = -1;
        busy_cycles = 0;
        for (int n = 1; n <= 40; n++) begin
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busy_cycles++;
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        total++;
        if ({quotient, remainder, busy, done, div_zero} !== 35'd0) begin
            bad++;
            $display("FAIL reset_outputs got q=%h r=%h busy=%b done=%b dz=%b want all 0",
                     quotient, remainder, busy, done, div_zero);
        end
        Reset_n = 1'b1;
    endtask

    task automatic test_unsigned();
        int lat, bc;
        run_op(16'd100, 16'd7, 1'b0, lat, bc);
        total++;
        if (lat !== 17) begin bad++; $display("FAIL unsigned_latency got %0d want 17", lat); end
        total++;
        if (bc !== 16) begin bad++; $display("FAIL unsigned_busy_cycles got %0d want 16", bc); end
        total++;
        if ({quotient, remainder, div_zero} !== {16'd14, 16'd2, 1'b0}) begin
            bad++;
            $display("FAIL unsigned_100_7 got q=%0d r=%0d dz=%b want q=14 r=2 dz=0",
                     quotient, remainder, div_zero);
        end
        // Outputs must hold while idle and done must be a single pulse.
        repeat (3) @(posedge Clk);
        #1;
        total++;
        if ({quotient, remainder, done, busy} !== {16'd14, 16'd2, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL idle_hold got q=%0d r=%0d done=%b busy=%b want 14 2 0 0",
                     quotient, remainder, done, busy);
        end
    endtask

    task automatic test_signed();
        int lat, bc;
        run_op(16'hFFF9, 16'h0002, 1'b1, lat, bc);
        total++;
        if ({quotient, remainder, div_zero, lat} !== {16'hFFFD, 16'hFFFF, 1'b0, 32'd17}) begin
            bad++;
            $display("FAIL signed_m7_2 got q=%h r=%h dz=%b lat=%0d want q=fffd r=ffff dz=0 lat=17",
                     quotient, remainder, div_zero, lat);
        end
        run_op(16'h0007, 16'hFFFE, 1'b1, lat, bc);
        total++;
        if ({quotient, remainder, div_zero} !== {16'hFFFD, 16'h0001, 1'b0}) begin
            bad++;
            $display("FAIL signed_7_m2 got q=%h r=%h dz=%b want q=fffd r=0001 dz=0",
                     quotient, remainder, div_zero);
        end
    endtask

    task automatic test_div_zero();
        int lat, bc;
        run_op(16'h1234, 16'h0000, 1'b0, lat, bc);
        total++;
        if ({lat, bc} !== {32'd1, 32'd0}) begin
            bad++;
            $display("FAIL divzero_latency got lat=%0d busy_cycles=%0d want 1 0", lat, bc);
        end
        total++;
        if ({quotient, remainder, div_zero} !== {16'hFFFF, 16'h1234, 1'b1}) begin
            bad++;
            $display("FAIL divzero_result got q=%h r=%h dz=%b want q=ffff r=1234 dz=1",
                     quotient, remainder, div_zero);
        end
        @(posedge Clk); #1;
        total++;
        if ({done, div_zero} !== 2'b01) begin
            bad++;
            $display("FAIL divzero_hold got done=%b dz=%b want done=0 dz=1", done, div_zero);
        end
    endtask

    task automatic test_overflow();
        int lat, bc;
        run_op(16'h8000, 16'hFFFF, 1'b1, lat, bc);
        total++;
        if ({quotient, remainder, div_zero} !== {16'h8000, 16'h0000, 1'b0}) begin
            bad++;
            $display("FAIL overflow_signed got q=%h r=%h dz=%b want q=8000 r=0000 dz=0",
                     quotient, remainder, div_zero);
        end
        run_op(16'hFFFF, 16'h0001, 1'b0, lat, bc);
        total++;
        if ({quotient, remainder} !== {16'hFFFF, 16'h0000}) begin
            bad++;
            $display("FAIL unsigned_ffff_1 got q=%h r=%h want q=ffff r=0000", quotient, remainder);
        end
        run_op(16'h0000, 16'h0009, 1'b0, lat, bc);
        total++;
        if ({quotient, remainder, lat} !== {16'h0000, 16'h0000, 32'd17}) begin
            bad++;
            $display("FAIL zero_dividend got q=%h r=%h lat=%0d want 0 0 17", quotient, remainder, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        // 100/7 accepted, then a 9/3 request while busy in RUN cycle 5.
        @(posedge Clk); #1;
        start = 1'b1; A = 16'd100; B = 16'd7; is_signed = 1'b0;
        @(posedge Clk); #1;
        start = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        start = 1'b1; A = 16'd9; B = 16'd3;
        @(posedge Clk); #1;
        start = 1'b0;
        lat = -1;
        for (int n = 6; n <= 40; n++) begin
            if (done) begin lat = n; break; end
            @(posedge Clk); #1;
        end
        total++;
        if ({quotient, remainder, lat} !== {16'd14, 16'd2, 32'd17}) begin
            bad++;
            $display("FAIL start_while_busy got q=%0d r=%0d lat=%0d want 14 2 17",
                     quotient, remainder, lat);
        end
        // Start in the DONE cycle is accepted.
        start = 1'b1; A = 16'd9; B = 16'd3; is_signed = 1'b0;
        @(posedge Clk); #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL done_cycle_accept busy=%b want 1", busy); end
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            if (done) begin lat = n; break; end
            @(posedge Clk); #1;
        end
        total++;
        if ({quotient, remainder, lat} !== {16'd3, 16'd0, 32'd17}) begin
            bad++;
            $display("FAIL start_in_done got q=%0d r=%0d lat=%0d want 3 0 17",
                     quotient, remainder, lat);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, bc;
        @(posedge Clk); #1;
        start = 1'b1; A = 16'd100; B = 16'd7; is_signed = 1'b0;
        @(posedge Clk); #1;
        start = 1'b0;
        repeat (7) @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        total++;
        if ({quotient, remainder, busy, done, div_zero} !== 35'd0) begin
            bad++;
            $display("FAIL reset_mid_run got q=%h r=%h busy=%b done=%b dz=%b want all 0",
                     quotient, remainder, busy, done, div_zero);
        end
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        run_op(16'd50, 16'd5, 1'b0, lat, bc);
        total++;
        if ({quotient, remainder, lat} !== {16'd10, 16'd0, 32'd17}) begin
            bad++;
            $display("FAIL after_reset_50_5 got q=%0d r=%0d lat=%0d want 10 0 17",
                     quotient, remainder, lat);
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, eq, er;
        logic        s, ez;
        int          elat, lat, bc;
        for (int i = 0; i < 150; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       b = 16'd0;
                1:       b = 16'($urandom_range(1, 15));
                2:       b = 16'hFFFF;
                3:       b = 16'h8000;
                default: b = 16'($urandom);
            endcase
            if ($urandom_range(0, 9) == 0) a = 16'h8000;
            s = 1'($urandom);
            ref_div(a, b, s, eq, er, ez, elat);
            run_op(a, b, s, lat, bc);
            total++;
            if ({quotient, remainder, div_zero, lat} !== {eq, er, ez, elat}) begin
                bad++;
                $display("FAIL random_%0d a=%h b=%h s=%b got q=%h r=%h dz=%b lat=%0d want q=%h r=%h dz=%b lat=%0d",
                         i, a, b, s, quotient, remainder, div_zero, lat, eq, er, ez, elat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
